// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioning stage: state encoding,
// 12 MHz timing defaults and small elaboration-time helpers.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 1 ms debounce, 0.5 s long-press, 0.1 s repeat at 12 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 12000;
    localparam int unsigned DEF_LONG_CYCLES     = 6000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 1200000;
    localparam bit          DEF_REPEAT_EN       = 1'b1;

    // ceil(log2(v)); returns 0 for v <= 1
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned max_f(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous pin. RESET_VAL is the pin's
// inactive level so a reset never looks like activity downstream.
module btn_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // shift the pin through the two stages
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    // chain registers, reset to the inactive pin level
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/btn_event_debounce.sv
// Button conditioning: synchronise BTN_N, debounce it, and emit registered
// single-cycle PRESS / RELEASE / LONG / REPEAT events plus a clean level.
//
// state        | meaning
// IDLE         | released and stable
// PRESS_WAIT   | low seen, counting stable low samples
// HELD         | press accepted, hold timer running
// RELEASE_WAIT | high seen while held, hold timer frozen
module btn_event_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit          REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_N,
    output logic BTN_LEVEL,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG,
    output logic REPEAT
);

    localparam int unsigned DB_W   = clog2_f(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HOLD_W = clog2_f(max_f(LONG_CYCLES, REPEAT_CYCLES)) + 1;

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic btn_s;

    btn_state_e        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_done_q, long_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;

    logic [HOLD_W-1:0] hold_adv;
    logic              long_adv;
    logic              long_fire;
    logic              rep_fire;

    btn_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (CLK),
        .rst   (RST),
        .d_in  (BTN_N),
        .q_out (btn_s)
    );

    // One cycle of hold timing: count to LONG, then cycle modulo REPEAT.
    // The counter is reset at each threshold so it can never wrap.
    always_comb begin
        hold_adv  = hold_q;
        long_adv  = long_done_q;
        long_fire = 1'b0;
        rep_fire  = 1'b0;
        if (!long_done_q) begin
            if (hold_q == LONG_LAST) begin
                long_fire = 1'b1;
                long_adv  = 1'b1;
                hold_adv  = '0;
            end else begin
                hold_adv = hold_q + HOLD_ONE;
            end
        end else if (REPEAT_EN) begin
            if (hold_q == REP_LAST) begin
                rep_fire = 1'b1;
                hold_adv = '0;
            end else begin
                hold_adv = hold_q + HOLD_ONE;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!btn_s) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end
            PRESS_WAIT: begin
                if (btn_s) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    db_cnt_d    = '0;
                    hold_d      = '0;
                    long_done_d = 1'b0;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            HELD: begin
                if (btn_s) begin
                    // release candidate takes priority over a due LONG/REPEAT
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = DB_ONE;
                end else begin
                    hold_d      = hold_adv;
                    long_done_d = long_adv;
                    long_d      = long_fire;
                    repeat_d    = rep_fire;
                end
            end
            RELEASE_WAIT: begin
                if (!btn_s) begin
                    // bounce: resume timing so only the high samples are lost
                    state_d     = HELD;
                    db_cnt_d    = '0;
                    hold_d      = hold_adv;
                    long_done_d = long_adv;
                    long_d      = long_fire;
                    repeat_d    = rep_fire;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    db_cnt_d  = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign BTN_LEVEL = level_q;
    assign PRESS     = press_q;
    assign RELEASE   = release_q;
    assign LONG      = long_q;
    assign REPEAT    = repeat_q;

endmodule
